hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage (F/D/E/M/W) CPU. It drives the Fetch stage's `EN`, the per-stage stall and flush controls, and the Execute-stage operand forwarding selects. It also holds the whole pipeline while a Memory-stage data access waits on the memory handshake. It sits beside the datapath, takes register addresses and control bits from every stage, and contains no datapath registers of its own.

## Interface
Parameters:
- `TIMEOUT` = 64: maximum MEM_WAIT cycles before a forced release.
- `CNT_W` = 16: width of the stall performance counter.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `RA1D`, `RA2D` in 4 each: Decode source register addresses.
- `RA1E`, `RA2E` in 4 each: Execute source register addresses.
- `WA3E`, `WA3M`, `WA3W` in 4 each: destination register per stage.
- `RegWriteE`, `RegWriteM`, `RegWriteW` in 1 each: register write enable per stage.
- `MemtoRegE` in 1: the Execute-stage instruction is a load.
- `PCSrcD`, `PCSrcE`, `PCSrcM`, `PCSrcW` in 1 each: the instruction writes r15.
- `BranchTakenE` in 1: BranchE && CondEXE.
- `MemReqM` in 1: Memory-stage data access request.
- `MemReadyM` in 1: data memory response/ack.
- `StatClr` in 1: synchronous clear of `StallCount`.
- `EN` out 1: Fetch PC register enable, equal to ~StallF.
- `StallD`, `StallE`, `StallM`, `StallW` out 1 each: stage register hold.
- `FlushD`, `FlushE` out 1 each: synchronous bubble insert.
- `ForwardAE`, `ForwardBE` out 2 each: operand select (00 regfile, 01 ResultW, 10 ALUOutM).
- `MemErr` out 1: one-cycle pulse on timeout release.
- `StallCount` out `CNT_W`: saturating count of cycles with EN low.

## Operation
- r15 is excluded from every hazard comparison, because the datapath supplies PC+8 for r15 reads.
- Match terms:
  - Match1X = (RA1D==WA3X)&&RegWriteX&&(RA1D!=15); Match2X is the same for RA2D.
  - LdStall = (Match1E|Match2E)&&MemtoRegE.
- PCWrPending = PCSrcD|PCSrcE|PCSrcM.
- MemStall is true when state==MEM_WAIT, or when state==RUN && MemReqM && !MemReadyM. It is a combinational early hold.
- Outputs in RUN, with MemStall=0:
  - StallF = LdStall|PCWrPending.
  - StallD = LdStall.
  - FlushD = PCWrPending|PCSrcW|BranchTakenE.
  - FlushE = LdStall|BranchTakenE.
  - StallE, StallM and StallW are 0.
- With MemStall=1:
  - StallF, StallD, StallE, StallM and StallW are all 1.
  - FlushD and FlushE are forced to 0. A hold never drops an instruction.
- FSM states, held in the package enum:
  - RUN -> MEM_WAIT when MemReqM && !MemReadyM. The wait counter loads 1.
  - MEM_WAIT -> RUN when MemReadyM. No error is raised.
  - MEM_WAIT -> RUN when the counter reaches TIMEOUT-1 && !MemReadyM. MemErr pulses in the transition cycle.
  - MEM_WAIT otherwise: the counter increments.
- If MemReadyM and the timeout occur in the same cycle, ready wins and MemErr stays 0.
- StallCount increments on each cycle with EN==0 and saturates at all-ones. StatClr has priority over the increment.
- Forwarding priority (A shown, B identical with RA2E):
  - M first: 10 if RegWriteM&&RA1E==WA3M&&RA1E!=15.
  - Then W: 01 if RegWriteW&&RA1E==WA3W&&RA1E!=15.
  - Otherwise 00.

## Timing
- Reset values: state=RUN, wait counter=0, StallCount=0, MemErr=0.
- During reset: EN=1, all Stall*=0, all Flush*=0, Forward*=00.
- All stall, flush and forward outputs are combinational from the current inputs and state, with zero-cycle latency.
- MemErr is registered off the transition, so it is high in the cycle after the timeout edge, for exactly one cycle.
- A load-use hazard gives exactly one bubble: one cycle with StallF/StallD/FlushE high, then clear.
- A PC write gives FlushD high for 4 consecutive cycles (D, E, M, W) and EN low for 3.
- Asserting rst mid-MEM_WAIT returns to RUN immediately and releases all stalls asynchronously.

## Configuration
- `HAZARD_FORWARDING_EN` defined:
  - Forwarding operates as described in Operation.
  - Only LdStall stalls on a data hazard.
- `HAZARD_FORWARDING_EN` undefined:
  - ForwardAE and ForwardBE are tied to 00.
  - The data-hazard stall becomes (Match1E|Match2E|Match1M|Match2M|Match1W|Match2W). It replaces LdStall in both the StallF/StallD terms and the FlushE term.
  - The register file is written before it is read within a cycle, so W matches are still stalled conservatively.

## Structure
- Package `hazard_pkg` holds:
  - The `hz_state_t` enum (RUN, MEM_WAIT).
  - The forward-select localparams FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - The r15 index constant PC_REG=4'd15.
- Sub-module `forward_unit`: a combinational match/forward-select generator, instantiated once and compiled out under the macro.
- The FSM, counters and stall/flush logic live in `hazard_ctrl`.

## Test plan
- Load-use: an LDR to r3 in E (MemtoRegE=1, WA3E=3, RegWriteE=1) with RA1D=3 -> StallF=1, StallD=1, FlushE=1 for one cycle; EN=1 the next cycle.
- Forwarding: RA1E=5 and WA3M=5 with RegWriteM=1, plus WA3W=5 with RegWriteW=1 -> ForwardAE=10. Remove the M match -> ForwardAE=01. With RA1E=15 -> ForwardAE=00.
- Branch: BranchTakenE=1 for one cycle -> FlushD=1 and FlushE=1 in that cycle. A PCSrcD pulse walking through the pipeline -> EN low for 3 cycles and FlushD high for 4 cycles.
- Memory wait: MemReqM=1, MemReadyM=0 for 5 cycles, then 1 -> all Stall* high for 6 cycles, flushes 0, MemErr=0, StallCount=6.
- Timeout: MemReadyM held at 0 with TIMEOUT=8 -> release after 8 stall cycles and a single MemErr pulse. In the same setup, ready and timeout in the same cycle -> no MemErr.
- Reset/saturation:
  - rst asserted mid-MEM_WAIT -> EN=1 immediately and state RUN.
  - With CNT_W=4, 20 stalled cycles -> StallCount=15.
  - StatClr -> StallCount=0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Feature macro used by the controller: HAZARD_FORWARDING_EN.
package hazard_pkg;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [3:0] PC_REG = 4'd15;

  // r15 reads come from PC+8 in the datapath, so they never match a writer.
  function automatic logic reg_match(input logic [3:0] ra, input logic [3:0] wa,
                                     input logic we);
    return we && (ra == wa) && (ra != PC_REG);
  endfunction

endpackage

// File: rtl/hazard_ctrl_forward_unit.sv
// Execute-stage operand forwarding select generator (Memory stage wins over Writeback).
module forward_unit
  import hazard_pkg::*;
(
  input  logic [3:0] RA1E,
  input  logic [3:0] RA2E,
  input  logic [3:0] WA3M,
  input  logic [3:0] WA3W,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE
);

  logic [1:0][3:0] ra;
  logic [1:0][1:0] fwd;

  assign ra[0] = RA1E;
  assign ra[1] = RA2E;

  for (genvar gi = 0; gi < 2; gi++) begin : g_operand
    assign fwd[gi] = reg_match(ra[gi], WA3M, RegWriteM) ? FWD_MEM :
                     reg_match(ra[gi], WA3W, RegWriteW) ? FWD_WB  : FWD_RF;
  end

  assign ForwardAE = fwd[0];
  assign ForwardBE = fwd[1];

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall/flush controller with memory-wait FSM and stall counter.
// HAZARD_FORWARDING_EN selects operand forwarding vs. conservative data-hazard stalls.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       RA1D,
  input  logic [3:0]       RA2D,
  input  logic [3:0]       RA1E,
  input  logic [3:0]       RA2E,
  input  logic [3:0]       WA3E,
  input  logic [3:0]       WA3M,
  input  logic [3:0]       WA3W,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             PCSrcD,
  input  logic             PCSrcE,
  input  logic             PCSrcM,
  input  logic             PCSrcW,
  input  logic             BranchTakenE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  input  logic             StatClr,
  output logic             EN,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             StallW,
  output logic             FlushD,
  output logic             FlushE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCount
);

  localparam int WCNT_W = $clog2(TIMEOUT + 1);

  hz_state_t         state_reg, state_next;
  logic [WCNT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic              mem_err_reg, mem_err_next;
  logic [CNT_W-1:0]  stall_cnt_reg;

  logic            mem_stall;
  logic            data_stall;
  logic            pc_wr_pending;
  logic            stall_f;
  logic [2:0][3:0] wa;
  logic [2:0]      we;
  logic [2:0]      match1, match2;

  // Index 0/1/2 = Execute/Memory/Writeback destination.
  assign wa = {WA3W, WA3M, WA3E};
  assign we = {RegWriteW, RegWriteM, RegWriteE};

  for (genvar gi = 0; gi < 3; gi++) begin : g_stage_match
    assign match1[gi] = reg_match(RA1D, wa[gi], we[gi]);
    assign match2[gi] = reg_match(RA2D, wa[gi], we[gi]);
  end

`ifdef HAZARD_FORWARDING_EN
  logic [1:0] fwd_a, fwd_b;
  logic       unused_late_match;

  forward_unit u_forward_unit (
    .RA1E      (RA1E),
    .RA2E      (RA2E),
    .WA3M      (WA3M),
    .WA3W      (WA3W),
    .RegWriteM (RegWriteM),
    .RegWriteW (RegWriteW),
    .ForwardAE (fwd_a),
    .ForwardBE (fwd_b)
  );

  assign data_stall        = (match1[0] | match2[0]) & MemtoRegE;
  assign unused_late_match = ^{match1[2:1], match2[2:1]};
  assign ForwardAE         = rst ? FWD_RF : fwd_a;
  assign ForwardBE         = rst ? FWD_RF : fwd_b;
`else
  logic unused_fwd_inputs;

  // Without bypass paths any in-flight writer of a Decode source must drain first.
  assign data_stall        = |{match1, match2};
  assign unused_fwd_inputs = ^{RA1E, RA2E, MemtoRegE};
  assign ForwardAE         = FWD_RF;
  assign ForwardBE         = FWD_RF;
`endif

  assign pc_wr_pending = PCSrcD | PCSrcE | PCSrcM;

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    mem_err_next  = 1'b0;
    mem_stall     = 1'b0;
    case (state_reg)
      RUN: begin
        if (MemReqM && !MemReadyM) begin
          mem_stall     = 1'b1;
          state_next    = MEM_WAIT;
          wait_cnt_next = WCNT_W'(1);
        end
      end
      MEM_WAIT: begin
        mem_stall = 1'b1;
        if (MemReadyM) begin
          state_next    = RUN;
          wait_cnt_next = '0;
        end else if (wait_cnt_reg == WCNT_W'(TIMEOUT - 1)) begin
          state_next    = RUN;
          wait_cnt_next = '0;
          mem_err_next  = 1'b1;
        end else begin
          wait_cnt_next = wait_cnt_reg + WCNT_W'(1);
        end
      end
      default: state_next = RUN;
    endcase

    stall_f = 1'b0;
    StallD  = 1'b0;
    StallE  = 1'b0;
    StallM  = 1'b0;
    StallW  = 1'b0;
    FlushD  = 1'b0;
    FlushE  = 1'b0;
    // Reset releases every hold combinationally, not just at the next edge.
    if (!rst) begin
      if (mem_stall) begin
        stall_f = 1'b1;
        StallD  = 1'b1;
        StallE  = 1'b1;
        StallM  = 1'b1;
        StallW  = 1'b1;
      end else begin
        stall_f = data_stall | pc_wr_pending;
        StallD  = data_stall;
        FlushD  = pc_wr_pending | PCSrcW | BranchTakenE;
        FlushE  = data_stall | BranchTakenE;
      end
    end
  end

  assign EN = ~stall_f;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= RUN;
      wait_cnt_reg  <= '0;
      mem_err_reg   <= 1'b0;
      stall_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      mem_err_reg  <= mem_err_next;
      if (StatClr) begin
        stall_cnt_reg <= '0;
      end else if (stall_f && (stall_cnt_reg != '1)) begin
        stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      end
    end
  end

  assign MemErr     = mem_err_reg;
  assign StallCount = stall_cnt_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic
// compared against a behavioural model of the hazard rules.
module tb_hazard_ctrl;

  localparam int TO   = 8;
  localparam int CW   = 4;
  localparam int MAXC = 15;

`ifdef HAZARD_FORWARDING_EN
  localparam bit         FWD_ON  = 1'b1;
  localparam logic [1:0] EXP_MEM = 2'b10;
  localparam logic [1:0] EXP_WB  = 2'b01;
`else
  localparam bit         FWD_ON  = 1'b0;
  localparam logic [1:0] EXP_MEM = 2'b00;
  localparam logic [1:0] EXP_WB  = 2'b00;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic RegWriteE, RegWriteM, RegWriteW, MemtoRegE;
  logic PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE;
  logic MemReqM, MemReadyM, StatClr;
  logic EN, StallD, StallE, StallM, StallW, FlushD, FlushE, MemErr;
  logic [1:0] ForwardAE, ForwardBE;
  logic [CW-1:0] StallCount;

  int vectors = 0;
  int miscompares = 0;

  // model state
  bit m_waiting;
  int m_waited;
  bit m_err;
  int m_count;
  // model outputs
  bit exp_en, exp_sd, exp_se, exp_sm, exp_sw, exp_fd, exp_fe;
  logic [1:0] exp_fa, exp_fb;

  hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE),
    .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
    .BranchTakenE(BranchTakenE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .StatClr(StatClr),
    .EN(EN), .StallD(StallD), .StallE(StallE), .StallM(StallM), .StallW(StallW),
    .FlushD(FlushD), .FlushE(FlushE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .MemErr(MemErr), .StallCount(StallCount)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit hit(input logic [3:0] ra, input logic [3:0] wa, input logic w);
    return w && (ra == wa) && (ra != 4'd15);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [3:0] ra);
    if (!FWD_ON) return 2'b00;
    if (hit(ra, WA3M, RegWriteM)) return 2'b10;
    if (hit(ra, WA3W, RegWriteW)) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_reset();
    m_waiting = 0; m_waited = 0; m_err = 0; m_count = 0;
  endtask

  task automatic model_eval();
    bit dh, pcw, hold;
    if (FWD_ON)
      dh = (hit(RA1D, WA3E, RegWriteE) || hit(RA2D, WA3E, RegWriteE)) && MemtoRegE;
    else
      dh = hit(RA1D, WA3E, RegWriteE) || hit(RA2D, WA3E, RegWriteE) ||
           hit(RA1D, WA3M, RegWriteM) || hit(RA2D, WA3M, RegWriteM) ||
           hit(RA1D, WA3W, RegWriteW) || hit(RA2D, WA3W, RegWriteW);
    pcw  = PCSrcD || PCSrcE || PCSrcM;
    hold = m_waiting || (MemReqM && !MemReadyM);
    exp_fa = rst ? 2'b00 : fwd_sel(RA1E);
    exp_fb = rst ? 2'b00 : fwd_sel(RA2E);
    if (rst) begin
      exp_en = 1; {exp_sd, exp_se, exp_sm, exp_sw, exp_fd, exp_fe} = '0;
    end else if (hold) begin
      exp_en = 0; {exp_sd, exp_se, exp_sm, exp_sw} = 4'hF; {exp_fd, exp_fe} = 2'b00;
    end else begin
      exp_en = !(dh || pcw);
      exp_sd = dh; {exp_se, exp_sm, exp_sw} = 3'b000;
      exp_fd = pcw || PCSrcW || BranchTakenE;
      exp_fe = dh || BranchTakenE;
    end
  endtask

  // Advance one clock and update the model with the inputs seen at that edge.
  task automatic cycle();
    bit new_err;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      model_eval();
      new_err = 0;
      if (m_waiting) begin
        m_waited++;
        if (MemReadyM) m_waiting = 0;
        else if (m_waited == TO) begin m_waiting = 0; new_err = 1; end
      end else if (MemReqM && !MemReadyM) begin
        m_waiting = 1; m_waited = 1;
      end
      m_err = new_err;
      if (StatClr) m_count = 0;
      else if (!exp_en && m_count < MAXC) m_count++;
    end
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    {RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W} = '0;
    {RegWriteE, RegWriteM, RegWriteW, MemtoRegE} = '0;
    {PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE} = '0;
    {MemReqM, MemReadyM, StatClr} = '0;
  endtask

  task automatic stat_clear();
    clear_inputs(); StatClr = 1; #1; cycle(); StatClr = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1; model_reset();
    PCSrcE = 1; MemReqM = 1; BranchTakenE = 1;
    RA1E = 5; RA2E = 5; WA3M = 5; RegWriteM = 1;
    #1;
    vectors++; if ({EN, StallD, StallE, StallM, StallW} !== 5'b10000) begin
      miscompares++; $display("FAIL reset_stalls: got %b want 10000", {EN, StallD, StallE, StallM, StallW}); end
    vectors++; if ({FlushD, FlushE} !== 2'b00) begin
      miscompares++; $display("FAIL reset_flush: got %b want 00", {FlushD, FlushE}); end
    vectors++; if ({ForwardAE, ForwardBE} !== 4'b0000) begin
      miscompares++; $display("FAIL reset_fwd: got %b want 0000", {ForwardAE, ForwardBE}); end
    vectors++; if (StallCount !== 4'd0 || MemErr !== 1'b0) begin
      miscompares++; $display("FAIL reset_regs: got cnt=%0d err=%b want 0 0", StallCount, MemErr); end
    cycle(); cycle();
    rst = 0; clear_inputs(); #1; cycle();
    $display("test_reset done");
  endtask

  task automatic test_load_use();
    clear_inputs();
    RA1D = 3; WA3E = 3; RegWriteE = 1; MemtoRegE = 1; #1;
    vectors++; if ({EN, StallD, FlushE, StallE, FlushD} !== 5'b01100) begin
      miscompares++; $display("FAIL load_use_bubble: got %b want 01100", {EN, StallD, FlushE, StallE, FlushD}); end
    cycle();
    // load has moved to M, bubble in E; Decode still reads r3
    MemtoRegE = 0; RegWriteE = 0; WA3E = 0; WA3M = 3; RegWriteM = 1; #1;
    vectors++; if ({EN, FlushE} !== (FWD_ON ? 2'b10 : 2'b01)) begin
      miscompares++; $display("FAIL load_use_next: got %b want %b", {EN, FlushE}, (FWD_ON ? 2'b10 : 2'b01)); end
    cycle();
    clear_inputs(); RA1D = 15; RA2D = 15; WA3E = 15; RegWriteE = 1; MemtoRegE = 1; #1;
    vectors++; if ({EN, StallD} !== 2'b10) begin
      miscompares++; $display("FAIL load_use_r15: got %b want 10", {EN, StallD}); end
    cycle();
    $display("test_load_use done");
  endtask

  task automatic test_forwarding();
    clear_inputs();
    RA1E = 5; RA2E = 5; WA3M = 5; RegWriteM = 1; WA3W = 5; RegWriteW = 1; #1;
    vectors++; if ({ForwardAE, ForwardBE} !== {EXP_MEM, EXP_MEM}) begin
      miscompares++; $display("FAIL fwd_mem: got %b %b want %b", ForwardAE, ForwardBE, EXP_MEM); end
    RegWriteM = 0; #1;
    vectors++; if ({ForwardAE, ForwardBE} !== {EXP_WB, EXP_WB}) begin
      miscompares++; $display("FAIL fwd_wb: got %b %b want %b", ForwardAE, ForwardBE, EXP_WB); end
    RA1E = 15; WA3M = 15; WA3W = 15; RegWriteM = 1; RA2E = 7; #1;
    vectors++; if ({ForwardAE, ForwardBE} !== 4'b0000) begin
      miscompares++; $display("FAIL fwd_r15: got %b %b want 00 00", ForwardAE, ForwardBE); end
    cycle();
    $display("test_forwarding done");
  endtask

  task automatic test_branch();
    clear_inputs(); BranchTakenE = 1; #1;
    vectors++; if ({EN, FlushD, FlushE} !== 3'b111) begin
      miscompares++; $display("FAIL branch_flush: got %b want 111", {EN, FlushD, FlushE}); end
    cycle();
    $display("test_branch done");
  endtask

  task automatic test_pc_write();
    int en_low = 0;
    int fd_high = 0;
    for (int k = 0; k < 6; k++) begin
      clear_inputs();
      case (k)
        0: PCSrcD = 1;
        1: PCSrcE = 1;
        2: PCSrcM = 1;
        3: PCSrcW = 1;
        default: ;
      endcase
      #1;
      if (!EN) en_low++;
      if (FlushD) fd_high++;
      cycle();
    end
    vectors++; if (en_low != 3 || fd_high != 4) begin
      miscompares++; $display("FAIL pc_write: got en_low=%0d flushd=%0d want 3 4", en_low, fd_high); end
    $display("test_pc_write done");
  endtask

  task automatic test_mem_wait();
    int bad = 0;
    stat_clear();
    for (int k = 0; k < 6; k++) begin
      MemReqM = 1; MemReadyM = (k == 5); BranchTakenE = 1; #1;
      if ({EN, StallD, StallE, StallM, StallW, FlushD, FlushE} !== 7'b0111100) bad++;
      cycle();
    end
    vectors++; if (bad != 0) begin
      miscompares++; $display("FAIL mem_wait_hold: got %0d bad cycles want 0", bad); end
    clear_inputs(); #1;
    vectors++; if (StallCount !== 4'd6 || MemErr !== 1'b0 || EN !== 1'b1) begin
      miscompares++; $display("FAIL mem_wait_end: got cnt=%0d err=%b en=%b want 6 0 1", StallCount, MemErr, EN); end
    cycle();
    $display("test_mem_wait done");
  endtask

  task automatic test_timeout();
    int bad = 0;
    stat_clear();
    for (int k = 0; k < TO; k++) begin
      MemReqM = 1; MemReadyM = 0; #1;
      if (EN !== 1'b0 || MemErr !== 1'b0) bad++;
      cycle();
    end
    vectors++; if (bad != 0) begin
      miscompares++; $display("FAIL timeout_hold: got %0d bad cycles want 0", bad); end
    clear_inputs(); #1;
    vectors++; if (EN !== 1'b1 || MemErr !== 1'b1 || StallCount !== 4'd8) begin
      miscompares++; $display("FAIL timeout_release: got en=%b err=%b cnt=%0d want 1 1 8", EN, MemErr, StallCount); end
    cycle(); #1;
    vectors++; if (MemErr !== 1'b0) begin
      miscompares++; $display("FAIL timeout_pulse: got err=%b want 0", MemErr); end
    cycle();
    $display("test_timeout done");
  endtask

  task automatic test_ready_at_timeout();
    int bad = 0;
    clear_inputs();
    for (int k = 0; k < TO; k++) begin
      MemReqM = 1; MemReadyM = (k == TO - 1); #1;
      if (EN !== 1'b0) bad++;
      cycle();
    end
    clear_inputs(); #1;
    vectors++; if (bad != 0 || EN !== 1'b1 || MemErr !== 1'b0) begin
      miscompares++; $display("FAIL ready_at_timeout: got bad=%0d en=%b err=%b want 0 1 0", bad, EN, MemErr); end
    cycle(); #1;
    vectors++; if (MemErr !== 1'b0) begin
      miscompares++; $display("FAIL ready_at_timeout_late: got err=%b want 0", MemErr); end
    cycle();
    $display("test_ready_at_timeout done");
  endtask

  task automatic test_reset_mid_wait();
    clear_inputs();
    for (int k = 0; k < 3; k++) begin MemReqM = 1; MemReadyM = 0; #1; cycle(); end
    #1;
    vectors++; if (EN !== 1'b0) begin
      miscompares++; $display("FAIL mid_wait_pre: got en=%b want 0", EN); end
    rst = 1; #1;
    vectors++; if (EN !== 1'b1 || {StallD, StallE, StallM, StallW} !== 4'b0000) begin
      miscompares++; $display("FAIL mid_wait_rst: got en=%b stalls=%b want 1 0000", EN, {StallD, StallE, StallM, StallW}); end
    cycle();
    rst = 0; clear_inputs(); #1;
    vectors++; if (EN !== 1'b1 || StallCount !== 4'd0) begin
      miscompares++; $display("FAIL mid_wait_run: got en=%b cnt=%0d want 1 0", EN, StallCount); end
    cycle();
    $display("test_reset_mid_wait done");
  endtask

  task automatic test_saturation();
    stat_clear();
    for (int k = 0; k < 20; k++) begin PCSrcE = 1; #1; cycle(); end
    PCSrcE = 1; StatClr = 1; #1;
    vectors++; if (StallCount !== 4'd15) begin
      miscompares++; $display("FAIL saturation: got %0d want 15", StallCount); end
    cycle();
    clear_inputs(); #1;
    vectors++; if (StallCount !== 4'd0) begin
      miscompares++; $display("FAIL statclr: got %0d want 0", StallCount); end
    cycle();
    $display("test_saturation done");
  endtask

  function automatic logic [3:0] rnd_reg();
    int v = $urandom_range(0, 4);
    return (v == 4) ? 4'd15 : 4'(v);
  endfunction

  task automatic test_random();
    int errs = 0;
    for (int i = 0; i < 600; i++) begin
      RA1D = rnd_reg(); RA2D = rnd_reg(); RA1E = rnd_reg(); RA2E = rnd_reg();
      WA3E = rnd_reg(); WA3M = rnd_reg(); WA3W = rnd_reg();
      RegWriteE = 1'($urandom); RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
      MemtoRegE = 1'($urandom);
      PCSrcD = ($urandom_range(0, 9) == 0); PCSrcE = ($urandom_range(0, 9) == 0);
      PCSrcM = ($urandom_range(0, 9) == 0); PCSrcW = ($urandom_range(0, 9) == 0);
      BranchTakenE = ($urandom_range(0, 6) == 0);
      MemReqM = ($urandom_range(0, 2) == 0);
      MemReadyM = ((i % 100) < 12) ? 1'b0 : 1'($urandom);
      StatClr = ($urandom_range(0, 40) == 0);
      #1;
      model_eval();
      vectors++; if ({EN, StallD, StallE, StallM, StallW, FlushD, FlushE} !==
                     {exp_en, exp_sd, exp_se, exp_sm, exp_sw, exp_fd, exp_fe}) begin
        miscompares++; errs++;
        if (errs < 10) $display("FAIL rand_ctl[%0d]: got %b want %b", i,
          {EN, StallD, StallE, StallM, StallW, FlushD, FlushE},
          {exp_en, exp_sd, exp_se, exp_sm, exp_sw, exp_fd, exp_fe});
      end
      vectors++; if ({ForwardAE, ForwardBE} !== {exp_fa, exp_fb}) begin
        miscompares++; errs++;
        if (errs < 10) $display("FAIL rand_fwd[%0d]: got %b %b want %b %b", i, ForwardAE, ForwardBE, exp_fa, exp_fb);
      end
      vectors++; if (StallCount !== 4'(m_count) || MemErr !== m_err) begin
        miscompares++; errs++;
        if (errs < 10) $display("FAIL rand_regs[%0d]: got cnt=%0d err=%b want %0d %b", i, StallCount, MemErr, m_count, m_err);
      end
      cycle();
    end
    $display("test_random done");
  endtask

  initial begin
    clear_inputs();
    model_reset();
    @(negedge clk);
    test_reset();
    test_load_use();
    test_forwarding();
    test_branch();
    test_pc_write();
    test_mem_wait();
    test_timeout();
    test_ready_at_timeout();
    test_reset_mid_wait();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
